// File: rtl/decode_pkg.sv
// Shared types and sizing for the decode hazard controller.
// Optional feature macro used by this slice: DECODE_WB_BYPASS_EN.
package decode_pkg;

    localparam int unsigned NREG   = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned PEND_W = 2;
    localparam int unsigned XLEN   = 32;

    typedef logic [REG_W-1:0]  reg_ind_t;
    typedef logic [XLEN-1:0]   xlen_t;
    typedef logic [PEND_W-1:0] pend_cnt_t;

    typedef enum logic {
        ARB_EMPTY = 1'b0,
        ARB_FULL  = 1'b1
    } arb_state_e;

    // One register-file write request (index + data)
    typedef struct packed {
        reg_ind_t ind;
        xlen_t    dat;
    } wr_req_t;

    localparam reg_ind_t  REG_ZERO = 5'd0;
    localparam pend_cnt_t PEND_MAX = '1;

endpackage

// File: rtl/wb_write_arb.sv
// Priority arbiter for the single RF write port: memory loads win,
// a colliding ALU writeback is parked in a 1-entry skid and written next cycle.
module wb_write_arb
    import decode_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    input  logic [REG_W-1:0]  wb_rd_ind,
    input  logic [XLEN-1:0]   wb_dat,
    output logic              wb_ready,
    input  logic              mem_valid,
    input  logic [REG_W-1:0]  mem_rd_ind,
    input  logic [XLEN-1:0]   mem_dat,
    output logic              mem_ready,
    output logic              rf_we,
    output logic [REG_W-1:0]  rf_waddr,
    output logic [XLEN-1:0]   rf_wdata
);

    arb_state_e state;
    arb_state_e state_nxt;
    wr_req_t    skid;
    logic       skid_load;
    wr_req_t    wr;
    logic       wr_v;

    // State register and skid capture of the losing writeback
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_EMPTY;
            skid  <= '0;
        end else begin
            state <= state_nxt;
            if (skid_load) begin
                skid <= '{ind: wb_rd_ind, dat: wb_dat};
            end
        end
    end

    // Next state, readies and the RF write-port mux
    always_comb begin
        state_nxt = state;
        skid_load = 1'b0;
        wb_ready  = 1'b1;
        mem_ready = 1'b1;
        wr_v      = 1'b0;
        wr        = '0;
        case (state)
            ARB_EMPTY: begin
                if (wb_valid && mem_valid) begin
                    wr_v      = 1'b1;
                    wr        = '{ind: mem_rd_ind, dat: mem_dat};
                    skid_load = 1'b1;
                    state_nxt = ARB_FULL;
                end else if (mem_valid) begin
                    wr_v = 1'b1;
                    wr   = '{ind: mem_rd_ind, dat: mem_dat};
                end else if (wb_valid) begin
                    wr_v = 1'b1;
                    wr   = '{ind: wb_rd_ind, dat: wb_dat};
                end
            end
            ARB_FULL: begin
                wb_ready  = 1'b0;
                mem_ready = 1'b0;
                wr_v      = 1'b1;
                wr        = skid;
                state_nxt = ARB_EMPTY;
            end
            default: state_nxt = ARB_EMPTY;
        endcase
        // x0 writes are accepted but never reach the register file
        rf_we    = wr_v && (wr.ind != REG_ZERO);
        rf_waddr = wr.ind;
        rf_wdata = wr.dat;
    end

endmodule

// File: rtl/decode_hazard_ctrl.sv
// Decode-stage sequencer: per-register in-flight scoreboard, RAW/WAW stall,
// redirect flush, and ownership of the RF write port via wb_write_arb.
// Optional feature macro: DECODE_WB_BYPASS_EN (forward the retiring write to decode).
module decode_hazard_ctrl
    import decode_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              dec_valid,
    input  logic [REG_W-1:0]  dec_rs1_ind,
    input  logic              dec_rs1_use,
    input  logic [REG_W-1:0]  dec_rs2_ind,
    input  logic              dec_rs2_use,
    input  logic [REG_W-1:0]  dec_rd_ind,
    input  logic              dec_rd_wr,
    input  logic              ex_redirect,
    output logic              dec_stall,
    output logic              dec_flush,
    input  logic              wb_valid,
    input  logic [REG_W-1:0]  wb_rd_ind,
    input  logic [XLEN-1:0]   wb_dat,
    output logic              wb_ready,
    input  logic              mem_valid,
    input  logic [REG_W-1:0]  mem_rd_ind,
    input  logic [XLEN-1:0]   mem_dat,
    output logic              mem_ready,
`ifdef DECODE_WB_BYPASS_EN
    output logic              rs1_byp,
    output logic              rs2_byp,
    output logic [XLEN-1:0]   byp_dat,
`endif
    output logic              rf_we,
    output logic [REG_W-1:0]  rf_waddr,
    output logic [XLEN-1:0]   rf_wdata
);

    pend_cnt_t pend_cnt [NREG];
    logic      rs1_fwd;
    logic      rs2_fwd;
    logic      rs1_pend;
    logic      rs2_pend;
    logic      raw;
    logic      waw_full;
    logic      issue;
    logic      retire;

    wb_write_arb u_arb (
        .clk        (clk),
        .rst        (rst),
        .wb_valid   (wb_valid),
        .wb_rd_ind  (wb_rd_ind),
        .wb_dat     (wb_dat),
        .wb_ready   (wb_ready),
        .mem_valid  (mem_valid),
        .mem_rd_ind (mem_rd_ind),
        .mem_dat    (mem_dat),
        .mem_ready  (mem_ready),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata)
    );

    // Hazard detection, stall/flush generation and scoreboard issue/retire strobes
    always_comb begin
        rs1_fwd = 1'b0;
        rs2_fwd = 1'b0;
`ifdef DECODE_WB_BYPASS_EN
        // The last in-flight write of a source is on the RF port this cycle
        rs1_fwd = rf_we && (rf_waddr == dec_rs1_ind) && (pend_cnt[dec_rs1_ind] == PEND_W'(1));
        rs2_fwd = rf_we && (rf_waddr == dec_rs2_ind) && (pend_cnt[dec_rs2_ind] == PEND_W'(1));
`endif
        rs1_pend  = dec_rs1_use && (pend_cnt[dec_rs1_ind] != '0) && !rs1_fwd;
        rs2_pend  = dec_rs2_use && (pend_cnt[dec_rs2_ind] != '0) && !rs2_fwd;
        raw       = rs1_pend || rs2_pend;
        waw_full  = dec_rd_wr && (pend_cnt[dec_rd_ind] == PEND_MAX);
        dec_stall = dec_valid && !ex_redirect && (raw || waw_full);
        dec_flush = ex_redirect || dec_stall;
        issue     = dec_valid && !dec_stall && !ex_redirect && dec_rd_wr
                    && (dec_rd_ind != REG_ZERO);
        retire    = rf_we && (rf_waddr != REG_ZERO);
    end

`ifdef DECODE_WB_BYPASS_EN
    assign rs1_byp = dec_rs1_use && rs1_fwd;
    assign rs2_byp = dec_rs2_use && rs2_fwd;
    assign byp_dat = rf_wdata;
`endif

    // Per-register in-flight counters; x0 is never tracked
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                pend_cnt[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (issue && (dec_rd_ind == REG_W'(i))
                    && !(retire && (rf_waddr == REG_W'(i)))) begin
                    pend_cnt[i] <= pend_cnt[i] + PEND_W'(1);
                end else if (retire && (rf_waddr == REG_W'(i))
                    && !(issue && (dec_rd_ind == REG_W'(i)))) begin
                    pend_cnt[i] <= pend_cnt[i] - PEND_W'(1);
                end
            end
        end
    end

    // A retire with nothing in flight means the scoreboard lost track of a writer
    always_ff @(posedge clk) begin
        if (!rst && retire) begin
            assert (pend_cnt[rf_waddr] != '0)
                else $error("retire of x%0d with zero pending writes", rf_waddr);
        end
    end

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Self-checking bench for decode_hazard_ctrl.
// Honours DECODE_WB_BYPASS_EN when defined for the build.
module tb_decode_hazard_ctrl;
    import decode_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             dec_valid;
    logic [REG_W-1:0] dec_rs1_ind;
    logic             dec_rs1_use;
    logic [REG_W-1:0] dec_rs2_ind;
    logic             dec_rs2_use;
    logic [REG_W-1:0] dec_rd_ind;
    logic             dec_rd_wr;
    logic             ex_redirect;
    logic             dec_stall;
    logic             dec_flush;
    logic             wb_valid;
    logic [REG_W-1:0] wb_rd_ind;
    logic [XLEN-1:0]  wb_dat;
    logic             wb_ready;
    logic             mem_valid;
    logic [REG_W-1:0] mem_rd_ind;
    logic [XLEN-1:0]  mem_dat;
    logic             mem_ready;
`ifdef DECODE_WB_BYPASS_EN
    logic             rs1_byp;
    logic             rs2_byp;
    logic [XLEN-1:0]  byp_dat;
`endif
    logic             rf_we;
    logic [REG_W-1:0] rf_waddr;
    logic [XLEN-1:0]  rf_wdata;

    typedef struct {
        int       cyc;
        reg_ind_t ind;
        xlen_t    dat;
    } exp_wr_t;

    exp_wr_t sbq[$];
    int      cyc;
    int      n_tests;
    int      n_fail;
    bit      rf_chk;

    always #5 clk = ~clk;

    decode_hazard_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .dec_valid   (dec_valid),
        .dec_rs1_ind (dec_rs1_ind),
        .dec_rs1_use (dec_rs1_use),
        .dec_rs2_ind (dec_rs2_ind),
        .dec_rs2_use (dec_rs2_use),
        .dec_rd_ind  (dec_rd_ind),
        .dec_rd_wr   (dec_rd_wr),
        .ex_redirect (ex_redirect),
        .dec_stall   (dec_stall),
        .dec_flush   (dec_flush),
        .wb_valid    (wb_valid),
        .wb_rd_ind   (wb_rd_ind),
        .wb_dat      (wb_dat),
        .wb_ready    (wb_ready),
        .mem_valid   (mem_valid),
        .mem_rd_ind  (mem_rd_ind),
        .mem_dat     (mem_dat),
        .mem_ready   (mem_ready),
`ifdef DECODE_WB_BYPASS_EN
        .rs1_byp     (rs1_byp),
        .rs2_byp     (rs2_byp),
        .byp_dat     (byp_dat),
`endif
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata)
    );

    // Drive every stimulus input to its idle value
    task automatic idle();
        dec_valid   = 1'b0;
        dec_rs1_ind = '0;
        dec_rs1_use = 1'b0;
        dec_rs2_ind = '0;
        dec_rs2_use = 1'b0;
        dec_rd_ind  = '0;
        dec_rd_wr   = 1'b0;
        ex_redirect = 1'b0;
        wb_valid    = 1'b0;
        wb_rd_ind   = '0;
        wb_dat      = '0;
        mem_valid   = 1'b0;
        mem_rd_ind  = '0;
        mem_dat     = '0;
    endtask

    // Close the current cycle: drain the RF-write scoreboard at negedge, then advance
    task automatic cycle();
        @(negedge clk);
        if (rf_chk) begin
            n_tests++;
            if (sbq.size() != 0 && sbq[0].cyc == cyc) begin
                if (rf_we !== 1'b1 || rf_waddr !== sbq[0].ind || rf_wdata !== sbq[0].dat) begin
                    n_fail++;
                    $display("FAIL rf_write cyc=%0d: got we=%b x%0d=%h, want we=1 x%0d=%h",
                             cyc, rf_we, rf_waddr, rf_wdata, sbq[0].ind, sbq[0].dat);
                end
                void'(sbq.pop_front());
            end else if (rf_we !== 1'b0) begin
                n_fail++;
                $display("FAIL rf_idle cyc=%0d: got we=%b x%0d=%h, want we=0",
                         cyc, rf_we, rf_waddr, rf_wdata);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Single-cycle issue of a writer of rd with no source operands
    task automatic issue_rd(input reg_ind_t rd);
        idle();
        dec_valid  = 1'b1;
        dec_rd_ind = rd;
        dec_rd_wr  = 1'b1;
        cycle();
        idle();
    endtask

    task automatic test_reset();
        int nz;
        idle();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        #2;
        n_tests++;
        if (dec_stall !== 1'b0 || dec_flush !== 1'b0 || rf_we !== 1'b0
            || wb_ready !== 1'b1 || mem_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_outputs: got stall=%b flush=%b we=%b wrdy=%b mrdy=%b, want 0 0 0 1 1",
                     dec_stall, dec_flush, rf_we, wb_ready, mem_ready);
        end
        nz = 0;
        for (int i = 0; i < NREG; i++) if (dut.pend_cnt[i] != '0) nz++;
        n_tests++;
        if (nz !== 0) begin
            n_fail++;
            $display("FAIL reset_pend: got %0d nonzero counters, want 0", nz);
        end
        cycle();
    endtask

    task automatic test_raw();
        issue_rd(5'd5);
        dec_valid   = 1'b1;
        dec_rs1_ind = 5'd5;
        dec_rs1_use = 1'b1;
        #2;
        n_tests++;
        if (dec_stall !== 1'b1 || dec_flush !== 1'b1) begin
            n_fail++;
            $display("FAIL raw_stall: got stall=%b flush=%b, want 1 1", dec_stall, dec_flush);
        end
        cycle();
        wb_valid  = 1'b1;
        wb_rd_ind = 5'd5;
        wb_dat    = 32'hDEAD_BEEF;
        sbq.push_back('{cyc, 5'd5, 32'hDEAD_BEEF});
        #2;
`ifdef DECODE_WB_BYPASS_EN
        n_tests++;
        if (dec_stall !== 1'b0 || rs1_byp !== 1'b1 || byp_dat !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL raw_bypass: got stall=%b byp=%b dat=%h, want 0 1 deadbeef",
                     dec_stall, rs1_byp, byp_dat);
        end
`else
        n_tests++;
        if (dec_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL raw_retire_cycle: got stall=%b, want 1", dec_stall);
        end
`endif
        cycle();
        wb_valid = 1'b0;
        #2;
        n_tests++;
        if (dec_stall !== 1'b0 || dec_flush !== 1'b0 || dut.pend_cnt[5] !== 2'd0) begin
            n_fail++;
            $display("FAIL raw_release: got stall=%b flush=%b pend5=%0d, want 0 0 0",
                     dec_stall, dec_flush, dut.pend_cnt[5]);
        end
        cycle();
        idle();
    endtask

    task automatic test_back_to_back();
        issue_rd(5'd3);
        issue_rd(5'd4);
        wb_valid   = 1'b1;
        wb_rd_ind  = 5'd3;
        wb_dat     = 32'h11;
        mem_valid  = 1'b1;
        mem_rd_ind = 5'd4;
        mem_dat    = 32'h22;
        sbq.push_back('{cyc, 5'd4, 32'h22});
        sbq.push_back('{cyc + 1, 5'd3, 32'h11});
        #2;
        n_tests++;
        if (wb_ready !== 1'b1 || mem_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept: got wrdy=%b mrdy=%b, want 1 1", wb_ready, mem_ready);
        end
        cycle();
        idle();
        #2;
        n_tests++;
        if (wb_ready !== 1'b0 || mem_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_full: got wrdy=%b mrdy=%b, want 0 0", wb_ready, mem_ready);
        end
        cycle();
        #2;
        n_tests++;
        if (wb_ready !== 1'b1 || mem_ready !== 1'b1
            || dut.pend_cnt[3] !== 2'd0 || dut.pend_cnt[4] !== 2'd0) begin
            n_fail++;
            $display("FAIL b2b_drain: got wrdy=%b mrdy=%b pend3=%0d pend4=%0d, want 1 1 0 0",
                     wb_ready, mem_ready, dut.pend_cnt[3], dut.pend_cnt[4]);
        end
        cycle();
    endtask

    task automatic test_waw();
        for (int k = 0; k < 3; k++) begin
            dec_valid  = 1'b1;
            dec_rd_ind = 5'd7;
            dec_rd_wr  = 1'b1;
            #2;
            n_tests++;
            if (dec_stall !== 1'b0) begin
                n_fail++;
                $display("FAIL waw_issue%0d: got stall=%b, want 0", k, dec_stall);
            end
            cycle();
        end
        wb_valid  = 1'b1;
        wb_rd_ind = 5'd7;
        wb_dat    = 32'h7777_0001;
        sbq.push_back('{cyc, 5'd7, 32'h7777_0001});
        #2;
        n_tests++;
        if (dec_stall !== 1'b1 || dec_flush !== 1'b1) begin
            n_fail++;
            $display("FAIL waw_full: got stall=%b flush=%b, want 1 1", dec_stall, dec_flush);
        end
        cycle();
        wb_valid = 1'b0;
        #2;
        n_tests++;
        if (dec_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL waw_release: got stall=%b, want 0", dec_stall);
        end
        cycle();
        idle();
        n_tests++;
        if (dut.pend_cnt[7] !== 2'd3) begin
            n_fail++;
            $display("FAIL waw_count: got %0d, want 3", dut.pend_cnt[7]);
        end
        for (int k = 0; k < 3; k++) begin
            wb_valid  = 1'b1;
            wb_rd_ind = 5'd7;
            wb_dat    = 32'h7777_0010 + 32'(k);
            sbq.push_back('{cyc, 5'd7, 32'h7777_0010 + 32'(k)});
            cycle();
        end
        idle();
        n_tests++;
        if (dut.pend_cnt[7] !== 2'd0) begin
            n_fail++;
            $display("FAIL waw_drain: got %0d, want 0", dut.pend_cnt[7]);
        end
    endtask

    task automatic test_redirect();
        issue_rd(5'd9);
        dec_valid   = 1'b1;
        dec_rs1_ind = 5'd9;
        dec_rs1_use = 1'b1;
        dec_rd_ind  = 5'd9;
        dec_rd_wr   = 1'b1;
        ex_redirect = 1'b1;
        #2;
        n_tests++;
        if (dec_stall !== 1'b0 || dec_flush !== 1'b1) begin
            n_fail++;
            $display("FAIL redirect_flush: got stall=%b flush=%b, want 0 1", dec_stall, dec_flush);
        end
        cycle();
        idle();
        n_tests++;
        if (dut.pend_cnt[9] !== 2'd1) begin
            n_fail++;
            $display("FAIL redirect_pend: got %0d, want 1", dut.pend_cnt[9]);
        end
        wb_valid  = 1'b1;
        wb_rd_ind = 5'd9;
        wb_dat    = 32'h9999_0000;
        sbq.push_back('{cyc, 5'd9, 32'h9999_0000});
        cycle();
        idle();
    endtask

    task automatic test_x0();
        wb_valid    = 1'b1;
        wb_rd_ind   = REG_ZERO;
        wb_dat      = 32'h55;
        dec_valid   = 1'b1;
        dec_rs1_ind = REG_ZERO;
        dec_rs1_use = 1'b1;
        dec_rs2_ind = REG_ZERO;
        dec_rs2_use = 1'b1;
        dec_rd_ind  = REG_ZERO;
        dec_rd_wr   = 1'b1;
        #2;
        n_tests++;
        if (wb_ready !== 1'b1 || rf_we !== 1'b0 || dec_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL x0_write: got wrdy=%b we=%b stall=%b, want 1 0 0",
                     wb_ready, rf_we, dec_stall);
        end
        cycle();
        idle();
        n_tests++;
        if (dut.pend_cnt[0] !== 2'd0) begin
            n_fail++;
            $display("FAIL x0_pend: got %0d, want 0", dut.pend_cnt[0]);
        end
    endtask

    task automatic test_reset_skid();
        int nz;
        issue_rd(5'd3);
        issue_rd(5'd4);
        wb_valid   = 1'b1;
        wb_rd_ind  = 5'd3;
        wb_dat     = 32'hAAAA_0003;
        mem_valid  = 1'b1;
        mem_rd_ind = 5'd4;
        mem_dat    = 32'hBBBB_0004;
        sbq.push_back('{cyc, 5'd4, 32'hBBBB_0004});
        cycle();
        idle();
        #2;
        n_tests++;
        if (wb_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_skid_full: got wrdy=%b, want 0", wb_ready);
        end
        rst    = 1'b1;
        rf_chk = 1'b0;
        cycle();
        rst    = 1'b0;
        rf_chk = 1'b1;
        #2;
        n_tests++;
        if (dut.u_arb.state !== ARB_EMPTY || rf_we !== 1'b0 || wb_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_skid_empty: got state=%0d we=%b wrdy=%b, want 0 0 1",
                     dut.u_arb.state, rf_we, wb_ready);
        end
        nz = 0;
        for (int i = 0; i < NREG; i++) if (dut.pend_cnt[i] != '0) nz++;
        n_tests++;
        if (nz !== 0) begin
            n_fail++;
            $display("FAIL rst_skid_pend: got %0d nonzero counters, want 0", nz);
        end
        cycle();
    endtask

    initial begin
        cyc     = 0;
        n_tests = 0;
        n_fail  = 0;
        rf_chk  = 1'b1;
        rst     = 1'b1;
        idle();
        test_reset();
        test_raw();
        test_back_to_back();
        test_waw();
        test_redirect();
        test_x0();
        test_reset_skid();
        n_tests++;
        if (sbq.size() !== 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d unmatched writes, want 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion by 100000, want completion");
        $fatal(1);
    end

endmodule
